// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and default sizing for rr_grant_arbiter
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  localparam int ARB_N = 8;
  localparam int ARB_IDX_W = $clog2(ARB_N);
  localparam int ARB_MAX_HOLD = 16;
endpackage

// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/grant bundle; master = requester side, slave = arbiter side
interface rr_grant_arbiter_if import arb_pkg::*; #(
  parameter int N = ARB_N,
  parameter int IDX_W = ARB_IDX_W
);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic gnt_valid;
  logic revoked;
  modport master (output req, input gnt, gnt_idx, gnt_valid, revoked);
  modport slave (input req, output gnt, gnt_idx, gnt_valid, revoked);
endinterface

// File: rtl/onehot_enc.sv
// onehot_enc: N-to-IDX_W one-hot to binary encoder (all-zero input gives 0)
module onehot_enc #(
  parameter int N = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     oh,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++)
      idx = oh[i] ? (idx | IDX_W'(i)) : idx;
  end
endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter with registered one-hot + binary grant.
// Optional hold timeout with forced revoke is enabled by defining ARB_TIMEOUT_EN.
module rr_grant_arbiter import arb_pkg::*; #(
  parameter int N = ARB_N,
  parameter int IDX_W = ARB_IDX_W
`ifdef ARB_TIMEOUT_EN
  , parameter int MAX_HOLD = ARB_MAX_HOLD
`endif
) (
  input logic clk,
  input logic rst,
  rr_grant_arbiter_if.slave bus
);
  arb_state_t state, state_n;
  logic [IDX_W-1:0] owner, owner_n, ptr, ptr_n, gnt_idx, gnt_idx_n, pick_idx;
  logic [N-1:0] gnt, gnt_n, rot, pick, pick_gnt;
  logic gnt_valid, gnt_valid_n, revoked, revoked_n, expire;
  // rotate so ptr sits at bit 0, take lowest set bit, rotate back
  assign rot = N'({bus.req, bus.req} >> ptr);
  assign pick = rot & (~rot + N'(1));
  assign pick_gnt = N'(({pick, pick} << ptr) >> N);
  onehot_enc #(.N(N), .IDX_W(IDX_W)) u_enc (.oh(pick_gnt), .idx(pick_idx));
`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  // counter parks at MAX_HOLD-1 so a requester arriving late still triggers a revoke
  assign expire = bus.req[owner] && hold_cnt == CNT_TOP && |(bus.req & ~gnt);
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n = ptr;
    gnt_n = gnt;
    gnt_idx_n = gnt_idx;
    gnt_valid_n = gnt_valid;
    revoked_n = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_n = hold_cnt;
`endif
    if (state == ARB_IDLE) begin
      if (|bus.req) begin
        state_n = ARB_BUSY;
        owner_n = pick_idx;
        gnt_n = pick_gnt;
        gnt_idx_n = pick_idx;
        gnt_valid_n = 1'b1;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_n = '0;
`endif
      end
    end else begin
`ifdef ARB_TIMEOUT_EN
      hold_cnt_n = (hold_cnt == CNT_TOP) ? hold_cnt : hold_cnt + 1'b1;
`endif
      if (!bus.req[owner] || expire) begin
        state_n = ARB_IDLE;
        gnt_n = '0;
        gnt_idx_n = '0;
        gnt_valid_n = 1'b0;
        ptr_n = owner + IDX_W'(1);
        revoked_n = expire;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= '0;
      ptr <= '0;
      gnt <= '0;
      gnt_idx <= '0;
      gnt_valid <= 1'b0;
      revoked <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr <= ptr_n;
      gnt <= gnt_n;
      gnt_idx <= gnt_idx_n;
      gnt_valid <= gnt_valid_n;
      revoked <= revoked_n;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= hold_cnt_n;
`endif
    end
  end
  assign bus.gnt = gnt;
  assign bus.gnt_idx = gnt_idx;
  assign bus.gnt_valid = gnt_valid;
  assign bus.revoked = revoked;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed + random checks of rr_grant_arbiter against a behavioural model
module tb_rr_grant_arbiter;
  localparam int N = 8;
  localparam int IDX_W = 3;
  localparam int MH = 4;
  logic clk, rst;
  int errors = 0, checks = 0;
  rr_grant_arbiter_if #(.N(N), .IDX_W(IDX_W)) bus ();
  rr_grant_arbiter #(.N(N), .IDX_W(IDX_W)
`ifdef ARB_TIMEOUT_EN
    , .MAX_HOLD(MH)
`endif
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  // model: who owns the resource, where the search starts, how long the owner has held it
  logic m_busy = 1'b0, m_rev = 1'b0, seen = 1'b0;
  int m_owner = 0, m_ptr = 0, m_held = 0;
  always @(posedge clk) begin
    int p;
    p = -1;
    for (int k = N - 1; k >= 0; k--)
      if (bus.req[(m_ptr + k) % N]) p = (m_ptr + k) % N;
    seen <= 1'b1;
    if (rst) begin
      m_busy <= 1'b0; m_owner <= 0; m_ptr <= 0; m_rev <= 1'b0; m_held <= 0;
    end else begin
      m_rev <= 1'b0;
      if (!m_busy) begin
        if (p >= 0) begin m_busy <= 1'b1; m_owner <= p; m_held <= 0; end
      end else if (!bus.req[m_owner]) begin
        m_busy <= 1'b0; m_ptr <= (m_owner + 1) % N;
`ifdef ARB_TIMEOUT_EN
      end else if (m_held + 1 >= MH && (bus.req & ~(N'(1) << m_owner)) != '0) begin
        m_busy <= 1'b0; m_ptr <= (m_owner + 1) % N; m_rev <= 1'b1;
`endif
      end else m_held <= m_held + 1;
    end
  end
  always @(negedge clk) if (seen) begin
    chk("model_gnt", bus.gnt, m_busy ? 32'(N'(1) << m_owner) : 32'd0);
    chk("model_idx", bus.gnt_idx, m_busy ? 32'(m_owner) : 32'd0);
    chk("model_valid", bus.gnt_valid, m_busy);
    chk("model_revoked", bus.revoked, m_rev);
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.req = 8'hFF;
    repeat (2) begin
      tick();
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_idx", bus.gnt_idx, 0);
      chk("rst_valid", bus.gnt_valid, 0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", bus.gnt, 8'h01);
    chk("post_rst_idx", bus.gnt_idx, 0);
    // single request, hold, release, next search starts at 5
    bus.req = '0; do_reset();
    bus.req = 8'b0001_0000;
    repeat (5) begin
      tick();
      chk("single_gnt", bus.gnt, 8'b0001_0000);
      chk("single_idx", bus.gnt_idx, 4);
    end
    bus.req = '0;
    tick();
    chk("single_rel", bus.gnt, 0);
    bus.req = 8'hFF;
    tick();
    chk("single_ptr5", bus.gnt, 8'h20);
    chk("single_ptr5_idx", bus.gnt_idx, 5);
    // rotation with one-cycle gap between owners
    bus.req = '0; do_reset();
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("rot_gnt", bus.gnt, 32'(8'(1) << (k % N)));
      chk("rot_idx", bus.gnt_idx, k % N);
      tick();
      tick();
      bus.req = 8'hFF & ~(8'(1) << (k % N));
      tick();
      chk("rot_gap", bus.gnt_valid, 0);
      bus.req = 8'hFF;
    end
    // wrap: ptr = 7 after owner 6
    bus.req = '0; do_reset();
    bus.req = 8'h40;
    tick();
    chk("wrap_own6", bus.gnt, 8'h40);
    bus.req = '0;
    tick();
    bus.req = 8'b1000_0001;
    tick();
    chk("wrap_7", bus.gnt, 8'h80);
    chk("wrap_7_idx", bus.gnt_idx, 7);
    bus.req = 8'b0000_0001;
    tick();
    chk("wrap_gap", bus.gnt, 0);
    tick();
    chk("wrap_0", bus.gnt, 8'h01);
    // reset mid-grant
    bus.req = '0; do_reset();
    bus.req = 8'h08;
    tick();
    chk("mid_own3", bus.gnt_idx, 3);
    rst = 1'b1;
    bus.req = 8'b0000_1010;
    tick();
    chk("mid_rst_gnt", bus.gnt, 0);
    rst = 1'b0;
    tick();
    chk("mid_first", bus.gnt, 8'h02);
    chk("mid_first_idx", bus.gnt_idx, 1);
`ifdef ARB_TIMEOUT_EN
    bus.req = '0; do_reset();
    bus.req = 8'h04;
    tick();
    chk("to_gnt", bus.gnt, 8'h04);
    bus.req = 8'h24;
    repeat (3) begin
      tick();
      chk("to_hold", bus.gnt, 8'h04);
    end
    tick();
    chk("to_drop", bus.gnt, 0);
    chk("to_rev", bus.revoked, 1);
    tick();
    chk("to_next", bus.gnt, 8'h20);
    chk("to_next_idx", bus.gnt_idx, 5);
    chk("to_rev_end", bus.revoked, 0);
    bus.req = '0; do_reset();
    bus.req = 8'h04;
    repeat (20) begin
      tick();
      chk("alone_gnt", bus.gnt, 8'h04);
      chk("alone_rev", bus.revoked, 0);
    end
`endif
    // random traffic, model compare runs every cycle
    bus.req = '0; do_reset();
    repeat (3000) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) bus.req = 8'($urandom);
      else if (r < 5) bus.req = bus.req ^ (8'(1) << $urandom_range(0, N - 1));
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    bus.req = '0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
